// File: rtl/nios2_debug_monitor_mem_if.sv
`default_nettype none
// ============================================================================
// nios2_debug_monitor_mem_if : JTAG ocimem strobes, CPU Avalon slave and
// monitor status bundle for the debug monitor RAM.   Rev 1.0
// ============================================================================
interface nios2_debug_monitor_mem_if #(
   parameter int ADDR_W = 8
);
   logic [37:0]       jdo;
   logic              take_action_ocimem_a;
   logic              take_no_action_ocimem_a;
   logic              take_action_ocimem_b;
   logic [ADDR_W-1:0] avs_address;
   logic              avs_read;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic [3:0]        avs_byteenable;
   logic [31:0]       avs_readdata;
   logic              avs_waitrequest;
   logic [31:0]       MonDReg;
   logic              monitor_ready;
   logic              monitor_error;

   modport master (
      output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
      output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      input  avs_readdata, avs_waitrequest, MonDReg, monitor_ready, monitor_error
   );

   modport slave (
      input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
      input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      output avs_readdata, avs_waitrequest, MonDReg, monitor_ready, monitor_error
   );
endinterface
`default_nettype wire

// File: rtl/nios2_debug_monitor_mem.sv
`default_nettype none
// ============================================================================
// nios2_debug_monitor_mem : monitor RAM shared between JTAG ocimem accesses
// (MonAReg/MonDReg) and CPU Avalon accesses.   Rev 1.0
// ============================================================================
module nios2_debug_monitor_mem #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 160
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   nios2_debug_monitor_mem_if.slave   bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_J_RD  = 3'd1;
   localparam logic [2:0] S_J_CAP = 3'd2;
   localparam logic [2:0] S_J_WR  = 3'd3;
   localparam logic [2:0] S_C_RD  = 3'd4;
   localparam logic [2:0] S_C_CAP = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] mon_a_q;
   logic [31:0]       mon_d_q;
   logic              err_q;
   logic [31:0]       avs_rdata_q;
   logic [31:0]       jrd_q;
   logic [31:0]       wdata_q;
   logic [31:0]       mem_q [DEPTH];

   logic              w_idle, w_any_strobe, w_cpu_wr_acc;
   logic [ADDR_W-1:0] w_rd_addr;
   logic              w_rd_in_range, w_mon_in_range, w_avs_in_range;
   logic [IDX_W-1:0]  w_rd_idx, w_mon_idx, w_avs_idx;
   logic [31:0]       w_rd_word;
   logic              w_unused;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return 32'(a) < 32'(DEPTH);
   endfunction

   assign w_unused     = ^{bus.jdo[37:35], bus.jdo[2:0]};
   assign w_idle       = (state_q == S_IDLE);
   assign w_any_strobe = bus.take_action_ocimem_a | bus.take_no_action_ocimem_a
                       | bus.take_action_ocimem_b;
   assign w_cpu_wr_acc = w_idle & bus.avs_write & ~w_any_strobe;

   // Out-of-range addresses are steered to word 0 so the array is never over-indexed.
   assign w_mon_in_range = in_range(mon_a_q);
   assign w_avs_in_range = in_range(bus.avs_address);
   assign w_rd_in_range  = in_range(w_rd_addr);
   assign w_mon_idx      = w_mon_in_range ? IDX_W'(mon_a_q) : '0;
   assign w_avs_idx      = w_avs_in_range ? IDX_W'(bus.avs_address) : '0;
   assign w_rd_idx       = w_rd_in_range ? IDX_W'(w_rd_addr) : '0;
   assign w_rd_word      = mem_q[w_rd_idx];

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.take_action_ocimem_b)         state_d = S_J_WR;
            else if (bus.take_action_ocimem_a)    state_d = bus.jdo[34] ? S_J_RD : S_IDLE;
            else if (bus.take_no_action_ocimem_a) state_d = S_J_RD;
            else if (bus.avs_read)                state_d = S_C_RD;
         end
         S_J_RD:  state_d = S_J_CAP;
         S_J_CAP: state_d = S_IDLE;
         S_J_WR:  state_d = S_IDLE;
         S_C_RD:  state_d = S_C_CAP;
         S_C_CAP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.monitor_ready   = reset | w_idle;
      bus.avs_waitrequest = 1'b1;
      w_rd_addr           = bus.avs_address;
      if (!reset && ((state_q == S_C_CAP) || w_cpu_wr_acc))
         bus.avs_waitrequest = 1'b0;
      if (state_q == S_J_RD)
         w_rd_addr = mon_a_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mon_a_q     <= '0;
         mon_d_q     <= '0;
         err_q       <= 1'b0;
         avs_rdata_q <= '0;
         jrd_q       <= '0;
         wdata_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.take_action_ocimem_b) begin
                  wdata_q <= bus.jdo[34:3];
               end else if (bus.take_action_ocimem_a) begin
                  mon_a_q <= bus.jdo[17 +: ADDR_W];
                  err_q   <= 1'b0;
               end else if (bus.take_no_action_ocimem_a) begin
                  mon_a_q <= mon_a_q + 1'b1;
               end
            end
            S_J_RD: jrd_q <= w_rd_word;
            S_J_CAP: begin
               if (w_mon_in_range) begin
                  mon_d_q <= jrd_q;
               end else begin
                  mon_d_q <= 32'hDEAD_BEEF;
                  err_q   <= 1'b1;
               end
            end
            S_J_WR: begin
               mon_a_q <= mon_a_q + 1'b1;
               if (!w_mon_in_range) err_q <= 1'b1;
            end
            S_C_RD: avs_rdata_q <= w_rd_in_range ? w_rd_word : 32'h0;
            default: ;
         endcase
         // Strobes outside IDLE are protocol violations from the host.
         if (!w_idle && w_any_strobe) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if ((state_q == S_J_WR) && w_mon_in_range) begin
            mem_q[w_mon_idx] <= wdata_q;
         end else if (w_cpu_wr_acc && w_avs_in_range) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.avs_byteenable[b])
                  mem_q[w_avs_idx][8*b +: 8] <= bus.avs_writedata[8*b +: 8];
            end
         end
      end
   end

   assign bus.MonDReg       = mon_d_q;
   assign bus.monitor_error = err_q;
   assign bus.avs_readdata  = avs_rdata_q;
endmodule
`default_nettype wire
